// File: rtl/sme_pkg.sv
// sme_pkg: shared definitions for the string-match-engine host driver.
//   state_t  : driver FSM states
//   err_t    : result error codes reported on res_err
//   CH_*     : engine meta-characters (anchors / wildcards) for host software
//   *_DEF    : default buffer depths and engine-answer timeout
package sme_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND_S = 3'd2,
    SEND_P = 3'd3,
    WAIT   = 3'd4,
    RESULT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_NOSTR   = 2'd2,
    ERR_OVF     = 2'd3
  } err_t;

  localparam logic [7:0] CH_HEAD = 8'h5E;  // '^'
  localparam logic [7:0] CH_TAIL = 8'h24;  // '$'
  localparam logic [7:0] CH_ANY  = 8'h2E;  // '.'
  localparam logic [7:0] CH_STAR = 8'h2A;  // '*'

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: byte buffer for one job's string or pattern.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop contents and rewind the read pointer
//   wr_en/wr_data : append a byte; silently dropped when full
//   rd_en      : advance read pointer (one byte consumed this cycle)
//   rd_data    : registered read, always shows mem[rd_ptr]
//   count      : bytes held; full = (count == DEPTH)
//   rd_last    : current rd_data is the final stored byte
module sme_char_buf #(
  parameter  int DEPTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          rd_last
);

  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [7:0]    rd_data_reg;
  logic          wr_do;
  logic [AW-1:0] wr_addr, rd_addr;

  assign full    = (count_reg == CW'(DEPTH));
  assign wr_do   = wr_en && !full;
  assign wr_addr = count_reg[AW-1:0];
  assign rd_addr = rd_ptr_next[AW-1:0];

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    if (clear) begin
      count_next  = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_do) count_next = count_reg + CW'(1);
      if (rd_en) rd_ptr_next = rd_ptr_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_addr] <= wr_data;
  end

  // Read the address the pointer will hold next cycle so rd_data lines up
  // with rd_ptr_reg. Write-first bypass covers a 1-byte pattern whose only
  // byte is written on the very edge that launches the send.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      count_reg   <= count_next;
      rd_ptr_reg  <= rd_ptr_next;
      rd_data_reg <= (wr_do && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;
  assign rd_last = ((rd_ptr_reg + CW'(1)) == count_reg);

endmodule

// File: rtl/sme_host_driver.sv
// sme_host_driver: buffers one string-match job, streams it to the engine,
// waits for the engine result and offers it on a ready/valid port.
//   clk, reset                     : clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_sel/ld_data/ld_last : job load beats (sel 0 string, 1 pattern)
//   chardata/isstring/ispattern    : byte stream to the engine
//   valid/match/match_index        : engine result pulse
//   res_valid/res_ready/res_match/res_index/res_err : held result
//   busy                           : driver not idle
module sme_host_driver
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic       ld_sel,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_err,
  output logic       busy
);

  localparam int SCW = $clog2(STR_MAX + 1);
  localparam int PCW = $clog2(PAT_MAX + 1);

  state_t     state_reg, state_next;
  logic [7:0] tmo_reg, tmo_next;
  logic       ovf_reg, ovf_next;
  logic       str_sent_reg, str_sent_next;
  logic       res_match_reg, res_match_next;
  logic [4:0] res_index_reg, res_index_next;
  err_t       res_err_reg, res_err_next;

  logic           accept, close_job, no_str_err, buf_clear, timed_out;
  logic [7:0]     str_rd_data, pat_rd_data;
  logic [SCW-1:0] str_count;
  logic [PCW-1:0] pat_count;
  logic           str_full, pat_full, str_last, pat_last;

  assign accept     = ld_valid && ((state_reg == IDLE) || (state_reg == LOAD));
  // ld_last only closes a job on a pattern beat
  assign close_job  = accept && ld_sel && ld_last;
  // Pattern-only job with no string ever loaded into the engine
  assign no_str_err = close_job && (str_count == '0) && !str_sent_reg;
  assign buf_clear  = (state_reg == RESULT) && res_ready;
  assign timed_out  = (tmo_reg == 8'(TIMEOUT - 1));

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (accept && !ld_sel),
    .wr_data (ld_data),
    .rd_en   (state_reg == SEND_S),
    .rd_data (str_rd_data),
    .count   (str_count),
    .full    (str_full),
    .rd_last (str_last)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (accept && ld_sel),
    .wr_data (ld_data),
    .rd_en   (state_reg == SEND_P),
    .rd_data (pat_rd_data),
    .count   (pat_count),
    .full    (pat_full),
    .rd_last (pat_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, LOAD: begin
        if (close_job) begin
          if (str_count != '0)   state_next = SEND_S;
          else if (str_sent_reg) state_next = SEND_P;
          else                   state_next = RESULT;
        end else if (accept) begin
          state_next = LOAD;
        end
      end
      SEND_S: if (str_last) state_next = SEND_P;
      // count==0 cannot occur after a close; exit anyway rather than stall
      SEND_P: if (pat_last || (pat_count == '0)) state_next = WAIT;
      WAIT:   if (valid || timed_out) state_next = RESULT;
      RESULT: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    if (state_reg == SEND_S) begin
      isstring = 1'b1;
      chardata = str_rd_data;
    end else if (state_reg == SEND_P) begin
      ispattern = 1'b1;
      chardata  = pat_rd_data;
    end
    ld_ready  = (state_reg == IDLE) || (state_reg == LOAD);
    res_valid = (state_reg == RESULT);
    busy      = (state_reg != IDLE);
  end

  // Timeout counter, overflow/str_sent flags and result capture
  always_comb begin
    tmo_next       = (state_reg == WAIT) ? tmo_reg + 8'd1 : 8'd0;
    str_sent_next  = str_sent_reg || ((state_reg == SEND_S) && str_last);
    ovf_next       = ovf_reg;
    if (buf_clear)
      ovf_next = 1'b0;
    else if (accept && ((!ld_sel && str_full) || (ld_sel && pat_full)))
      ovf_next = 1'b1;

    res_match_next = res_match_reg;
    res_index_next = res_index_reg;
    res_err_next   = res_err_reg;
    if (no_str_err) begin
      res_match_next = 1'b0;
      res_index_next = 5'd0;
      res_err_next   = ERR_NOSTR;
    end else if (state_reg == WAIT) begin
      if (valid) begin
        res_match_next = match;
        res_index_next = match_index;
        res_err_next   = ovf_reg ? ERR_OVF : ERR_OK;
      end else if (timed_out) begin
        res_match_next = 1'b0;
        res_index_next = 5'd0;
        res_err_next   = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_reg       <= 8'd0;
      ovf_reg       <= 1'b0;
      str_sent_reg  <= 1'b0;
      res_match_reg <= 1'b0;
      res_index_reg <= 5'd0;
      res_err_reg   <= ERR_OK;
    end else begin
      tmo_reg       <= tmo_next;
      ovf_reg       <= ovf_next;
      str_sent_reg  <= str_sent_next;
      res_match_reg <= res_match_next;
      res_index_reg <= res_index_next;
      res_err_reg   <= res_err_next;
    end
  end

  assign res_match = res_match_reg;
  assign res_index = res_index_reg;
  assign res_err   = res_err_reg;

endmodule

// File: tb/tb_sme_host_driver.sv
module tb_sme_host_driver;

  logic       clk, reset;
  logic       ld_valid, ld_ready, ld_sel, ld_last;
  logic [7:0] ld_data, chardata;
  logic       isstring, ispattern;
  logic       valid, match;
  logic [4:0] match_index;
  logic       res_valid, res_ready, res_match, busy;
  logic [4:0] res_index;
  logic [1:0] res_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] s_buf [64];
  logic [7:0] p_buf [16];
  int ns, np, both;

  sme_host_driver dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_sel      (ld_sel),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_err     (res_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic sel, input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) load_beat(1'b0, s[i], 1'b0);
  endtask

  task automatic load_pat(input string s);
    for (int i = 0; i < s.len(); i++) load_beat(1'b1, s[i], (i == s.len() - 1));
  endtask

  // Called in the cycle after the job closes; records every strobed byte
  // until both strobes drop.
  task automatic capture();
    ns = 0; np = 0; both = 0;
    for (int c = 0; c < 80; c++) begin
      if (!isstring && !ispattern) break;
      if (isstring && ispattern) both++;
      if (isstring) begin
        s_buf[ns] = chardata;
        ns++;
      end else begin
        p_buf[np] = chardata;
        np++;
      end
      tick();
    end
  endtask

  task automatic check_stream(input string tag, input string es, input string ep);
    chk({tag, "_nstr"}, ns, es.len());
    chk({tag, "_npat"}, np, ep.len());
    chk({tag, "_both"}, both, 0);
    for (int i = 0; i < es.len(); i++) chk({tag, "_sbyte"}, s_buf[i], es[i]);
    for (int i = 0; i < ep.len(); i++) chk({tag, "_pbyte"}, p_buf[i], ep[i]);
  endtask

  task automatic engine_pulse(input logic m, input logic [4:0] idx);
    valid       = 1'b1;
    match       = m;
    match_index = idx;
    tick();
    valid       = 1'b0;
    match       = 1'b0;
    match_index = 5'd0;
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_rv_after"}, res_valid, 0);
    chk({tag, "_ldr_after"}, ld_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_chardata", chardata, 0);
    chk("rst_isstring", isstring, 0);
    chk("rst_ispattern", ispattern, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    reset = 1'b0;
    tick();

    // 1: "abcab" / "ca", engine reports match at 2
    load_str("abcab");
    load_pat("ca");
    chk("t1_first_strobe", isstring, 1);
    capture();
    check_stream("t1", "abcab", "ca");
    chk("t1_wait_chardata", chardata, 0);
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_ld_ready", ld_ready, 0);
    engine_pulse(1'b1, 5'd2);
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_match", res_match, 1);
    chk("t1_res_index", res_index, 2);
    chk("t1_res_err", res_err, 0);
    engine_pulse(1'b0, 5'd7);  // second valid in RESULT is ignored
    chk("t1_hold_match", res_match, 1);
    chk("t1_hold_index", res_index, 2);
    consume("t1");

    // 2: pattern-only "zz" reuses the engine's string
    engine_pulse(1'b1, 5'd9);  // valid while idle is ignored
    load_pat("zz");
    chk("t2_first_strobe", ispattern, 1);
    capture();
    check_stream("t2", "", "zz");
    engine_pulse(1'b0, 5'd0);
    chk("t2_res_valid", res_valid, 1);
    chk("t2_res_match", res_match, 0);
    chk("t2_res_index", res_index, 0);
    chk("t2_res_err", res_err, 0);
    consume("t2");

    // 3: after reset no string was ever sent
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t3_rst_busy", busy, 0);
    load_pat("a");
    chk("t3_isstring", isstring, 0);
    chk("t3_ispattern", ispattern, 0);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_res_err", res_err, 2);
    consume("t3");

    // 4: engine never answers
    load_str("q");
    load_pat("q");
    capture();
    check_stream("t4", "q", "q");
    match = 1'b1; match_index = 5'd9;  // no valid: must not be captured
    cnt = 0;
    while (!res_valid && cnt < 400) begin
      tick();
      cnt++;
    end
    match = 1'b0; match_index = 5'd0;
    chk("t4_wait_cycles", cnt, 255);
    chk("t4_res_err", res_err, 1);
    chk("t4_res_match", res_match, 0);
    chk("t4_res_index", res_index, 0);
    consume("t4");

    // 5: 34 string bytes overflow a 32-byte buffer
    for (int i = 0; i < 34; i++) load_beat(1'b0, 8'h40 + 8'(i), 1'b0);
    load_pat("x");
    capture();
    chk("t5_nstr", ns, 32);
    chk("t5_npat", np, 1);
    chk("t5_first", s_buf[0], 8'h40);
    chk("t5_last", s_buf[31], 8'h5F);
    chk("t5_pat", p_buf[0], 8'h78);
    engine_pulse(1'b1, 5'd3);
    chk("t5_res_err", res_err, 3);
    chk("t5_res_match", res_match, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) engine_pulse(1'b0, 5'd1);
      else tick();
    end
    chk("t5_hold_valid", res_valid, 1);
    chk("t5_hold_err", res_err, 3);
    chk("t5_hold_index", res_index, 3);
    consume("t5");

    // 6: reset in the middle of SEND_S
    load_str("hello");
    load_pat("l");
    chk("t6_sending", isstring, 1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_isstring", isstring, 0);
    chk("t6_ispattern", ispattern, 0);
    chk("t6_chardata", chardata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ld_ready", ld_ready, 1);
    load_pat("b");
    chk("t6_nostr_valid", res_valid, 1);
    chk("t6_nostr_err", res_err, 2);
    consume("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
